// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and defaults for the ALU arithmetic blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/half_subtractor.sv
// ============================================================================
// Module   : half_subtractor
// Brief    : Single-bit half subtractor, d = inA - inB with borrow-out b.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_subtractor (
    input  logic inA,
    input  logic inB,
    output logic d,
    output logic b
);

    assign d = inA ^ inB;
    assign b = ~inA & inB;

endmodule : half_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, LSB first, start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import alu_pkg::*;
#(
    parameter  int WIDTH = c_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_res;
    logic               r_bor;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_d1;
    logic               w_b1;
    logic               w_d_bit;
    logic               w_b2;
    logic               w_bor_nxt;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_final;

    // Full-subtractor cell: two half subtractors, borrows ORed.
    half_subtractor u_hs_ab (
        .inA (r_sa[0]),
        .inB (r_sb[0]),
        .d   (w_d1),
        .b   (w_b1)
    );

    half_subtractor u_hs_bor (
        .inA (w_d1),
        .inB (r_bor),
        .d   (w_d_bit),
        .b   (w_b2)
    );

    assign w_bor_nxt   = w_b1 | w_b2;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_final = {w_d_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_res  <= '0;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_bor <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= w_res_final;
                    r_bor <= w_bor_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Results publish on the edge entering DONE, untouched otherwise.
                    if (w_last) begin
                        diff   <= w_res_final;
                        borrow <= w_bor_nxt;
                        zero   <= (w_res_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule : serial_subtractor

`default_nettype wire
